// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg
// Shared constants for the memory-access stage: RV32I load/store funct3
// width codes and the byte-lane write masks used by the data RAM.
// No ports; imported by mem_stage and dmem_ram.
package mem_stage_pkg;

  // RV32I load/store width and sign codes (inst[14:12])
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Byte-lane write masks, bit i enables RAM byte i of the addressed word
  localparam logic [3:0] MASK_BYTE    = 4'b0001;
  localparam logic [3:0] MASK_HALF_LO = 4'b0011;
  localparam logic [3:0] MASK_HALF_HI = 4'b1100;
  localparam logic [3:0] MASK_WORD    = 4'b1111;
  localparam logic [3:0] MASK_NONE    = 4'b0000;

  // Lane mask for a store of the given width at the given byte offset.
  // Misalignment is rejected elsewhere; this only picks lanes.
  function automatic logic [3:0] store_mask(input logic [2:0] f3,
                                            input logic [1:0] lane);
    logic [3:0] m;
    m = MASK_NONE;
    case (f3)
      F3_B:    m = MASK_BYTE << lane;
      F3_H:    m = lane[1] ? MASK_HALF_HI : MASK_HALF_LO;
      F3_W:    m = MASK_WORD;
      default: m = MASK_NONE;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/dmem_ram.sv
// dmem_ram
// Single-port synchronous data RAM with per-byte write enables and a
// registered read port, written in a form that maps onto block RAM.
// Ports:
//   clk   - clock
//   en    - port enable; read and optional write happen on posedge
//   we    - byte write mask, bit i writes wdata[8i+7:8i]
//   addr  - word index
//   wdata - write data, already replicated into the enabled lanes
//   rdata - word read at the last enabled edge (old contents on a write)
module dmem_ram
  import mem_stage_pkg::*;
#(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  en,
  input  logic [3:0]            we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [31:0]           wdata,
  output logic [31:0]           rdata
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [31:0] mem [0:DEPTH-1];

  // No reset on the array or the read register so the tools can infer a
  // block RAM; the stage masks rdata with its own reset-cleared flags.
  always_ff @(posedge clk) begin
    if (en) begin
      for (int i = 0; i < 4; i++) begin
        if (we[i]) begin
          mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];
        end
      end
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/mem_stage.sv
// mem_stage
// Memory-access pipeline stage between the ALU and writeback. Performs
// RV32I loads/stores against an internal RAM and presents a registered
// result bundle one cycle after each op.
// Ports:
//   clk, rst_n      - clock, asynchronous active-low reset
//   valid_in        - an instruction occupies the stage this cycle
//   mem_read/write  - load / store
//   funct3          - width and sign code
//   alu_in          - byte address (also passed through as alu_out)
//   store_data      - rs2 value for stores
//   rd_in, reg_write_in - writeback destination and enable
//   valid_out, rd_out, reg_write_out, alu_out - registered bundle
//   load_data       - formatted load result, 0 when not a good load
//   is_load_out     - writeback selects load_data
//   err_out         - bundle was misaligned or illegal
//   err_sticky      - any error since reset
//   load_cnt, store_cnt - saturating counts of completed loads/stores
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 valid_in,
  input  logic                 mem_read,
  input  logic                 mem_write,
  input  logic [2:0]           funct3,
  input  logic [31:0]          alu_in,
  input  logic [31:0]          store_data,
  input  logic [4:0]           rd_in,
  input  logic                 reg_write_in,
  output logic                 valid_out,
  output logic [4:0]           rd_out,
  output logic                 reg_write_out,
  output logic [31:0]          alu_out,
  output logic [31:0]          load_data,
  output logic                 is_load_out,
  output logic                 err_out,
  output logic                 err_sticky,
  output logic [CNT_WIDTH-1:0] load_cnt,
  output logic [CNT_WIDTH-1:0] store_cnt
);

  logic [ADDR_WIDTH-1:0] word_idx;
  logic [1:0]            lane;
  logic                  is_load_op;
  logic                  is_store_op;
  logic                  legal_ld_f3;
  logic                  legal_st_f3;
  logic                  misaligned;
  logic                  access_err;
  logic [3:0]            ram_we;
  logic                  ram_en;
  logic [31:0]           ram_wdata;
  logic [31:0]           ram_rdata;

  // Registered copies of what formatting needs once the RAM word arrives
  logic [2:0]            f3_q;
  logic [1:0]            lane_q;
  logic                  good_load_q;

  logic [7:0]            sel_byte;
  logic [15:0]           sel_half;
  logic [31:0]           fmt_data;

  assign word_idx = alu_in[ADDR_WIDTH+1:2];
  assign lane     = alu_in[1:0];

  // Decode, error check and store lane/data preparation for the op
  // currently presented. An error suppresses the RAM write entirely.
  always_comb begin
    is_load_op  = valid_in & mem_read;
    is_store_op = valid_in & mem_write;

    legal_ld_f3 = 1'b0;
    case (funct3)
      F3_B, F3_H, F3_W, F3_BU, F3_HU: legal_ld_f3 = 1'b1;
      default:                        legal_ld_f3 = 1'b0;
    endcase

    legal_st_f3 = 1'b0;
    case (funct3)
      F3_B, F3_H, F3_W: legal_st_f3 = 1'b1;
      default:          legal_st_f3 = 1'b0;
    endcase

    // funct3[1:0] gives the size for both signed and unsigned codes
    misaligned = ((funct3[1:0] == 2'b01) && alu_in[0]) ||
                 ((funct3[1:0] == 2'b10) && (lane != 2'b00));

    access_err = (is_load_op | is_store_op) &
                 ((mem_read & mem_write) | misaligned |
                  (mem_read & ~legal_ld_f3) | (mem_write & ~legal_st_f3));

    ram_wdata = store_data;
    case (funct3)
      F3_B:    ram_wdata = {4{store_data[7:0]}};
      F3_H:    ram_wdata = {2{store_data[15:0]}};
      default: ram_wdata = store_data;
    endcase

    // rst_n gating keeps an op presented during reset from landing in RAM
    ram_we = MASK_NONE;
    if (is_store_op && !access_err && rst_n) begin
      ram_we = store_mask(funct3, lane);
    end

    ram_en = is_load_op | is_store_op;
  end

  dmem_ram #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .clk   (clk),
    .en    (ram_en),
    .we    (ram_we),
    .addr  (word_idx),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  // Result bundle register. rd and alu pass through unconditionally;
  // the enable-like fields are qualified by valid and error.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_out     <= 1'b0;
      rd_out        <= 5'd0;
      reg_write_out <= 1'b0;
      alu_out       <= 32'd0;
      is_load_out   <= 1'b0;
      err_out       <= 1'b0;
      err_sticky    <= 1'b0;
      f3_q          <= 3'd0;
      lane_q        <= 2'd0;
      good_load_q   <= 1'b0;
    end else begin
      valid_out     <= valid_in;
      rd_out        <= rd_in;
      reg_write_out <= reg_write_in & valid_in & ~access_err;
      alu_out       <= alu_in;
      is_load_out   <= is_load_op;
      err_out       <= access_err;
      err_sticky    <= err_sticky | access_err;
      f3_q          <= funct3;
      lane_q        <= lane;
      good_load_q   <= is_load_op & ~access_err;
    end
  end

  // Saturating activity counters; errored ops do not count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      load_cnt  <= '0;
      store_cnt <= '0;
    end else begin
      if (is_load_op && !access_err && (load_cnt != '1)) begin
        load_cnt <= load_cnt + 1'b1;
      end
      if (is_store_op && !access_err && (store_cnt != '1)) begin
        store_cnt <= store_cnt + 1'b1;
      end
    end
  end

  // Lane extraction and extension from the registered RAM word
  always_comb begin
    sel_byte = ram_rdata[{lane_q, 3'b000} +: 8];
    sel_half = lane_q[1] ? ram_rdata[31:16] : ram_rdata[15:0];
    fmt_data = 32'd0;
    case (f3_q)
      F3_B:    fmt_data = {{24{sel_byte[7]}}, sel_byte};
      F3_H:    fmt_data = {{16{sel_half[15]}}, sel_half};
      F3_W:    fmt_data = ram_rdata;
      F3_BU:   fmt_data = {24'd0, sel_byte};
      F3_HU:   fmt_data = {16'd0, sel_half};
      default: fmt_data = 32'd0;
    endcase
    load_data = good_load_q ? fmt_data : 32'd0;
  end

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage
// Scoreboard bench for mem_stage: the driver pushes a hand-computed
// expected bundle for every valid op, and an independent monitor pops and
// compares whenever valid_out is seen. The counters use a narrow width so
// saturation is reachable with a short run.
module tb_mem_stage;

  localparam int CW = 4;

  logic          clk;
  logic          rst_n;
  logic          valid_in;
  logic          mem_read;
  logic          mem_write;
  logic [2:0]    funct3;
  logic [31:0]   alu_in;
  logic [31:0]   store_data;
  logic [4:0]    rd_in;
  logic          reg_write_in;
  logic          valid_out;
  logic [4:0]    rd_out;
  logic          reg_write_out;
  logic [31:0]   alu_out;
  logic [31:0]   load_data;
  logic          is_load_out;
  logic          err_out;
  logic          err_sticky;
  logic [CW-1:0] load_cnt;
  logic [CW-1:0] store_cnt;

  mem_stage #(
    .ADDR_WIDTH (10),
    .CNT_WIDTH  (CW)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .valid_in      (valid_in),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .funct3        (funct3),
    .alu_in        (alu_in),
    .store_data    (store_data),
    .rd_in         (rd_in),
    .reg_write_in  (reg_write_in),
    .valid_out     (valid_out),
    .rd_out        (rd_out),
    .reg_write_out (reg_write_out),
    .alu_out       (alu_out),
    .load_data     (load_data),
    .is_load_out   (is_load_out),
    .err_out       (err_out),
    .err_sticky    (err_sticky),
    .load_cnt      (load_cnt),
    .store_cnt     (store_cnt)
  );

  typedef struct {
    logic [4:0]    rd;
    logic          rw;
    logic [31:0]   alu;
    logic [31:0]   ld;
    logic          isld;
    logic          err;
    logic          sticky;
    logic [CW-1:0] lc;
    logic [CW-1:0] sc;
  } exp_t;

  exp_t  sbq[$];
  string nameq[$];

  int checks = 0;
  int errors = 0;

  // Reference state the driver advances alongside each expected bundle
  logic [CW-1:0] model_lc = '0;
  logic [CW-1:0] model_sc = '0;
  logic          model_sticky = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string what, input logic [31:0] act,
                             input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", what, act, exp);
    end
  endtask

  // Drive one valid op at a negedge and queue its hand-computed bundle
  task automatic applyStimulus(input string name, input logic mr,
                               input logic mw, input logic [2:0] f3,
                               input logic [31:0] addr,
                               input logic [31:0] sd, input logic [4:0] rd,
                               input logic rw, input logic [31:0] exp_ld,
                               input logic exp_err);
    exp_t e;
    @(negedge clk);
    valid_in     = 1'b1;
    mem_read     = mr;
    mem_write    = mw;
    funct3       = f3;
    alu_in       = addr;
    store_data   = sd;
    rd_in        = rd;
    reg_write_in = rw;
    if (!exp_err && mr && model_lc != '1) model_lc = model_lc + 1'b1;
    if (!exp_err && mw && model_sc != '1) model_sc = model_sc + 1'b1;
    model_sticky = model_sticky | exp_err;
    e.rd     = rd;
    e.rw     = rw & ~exp_err;
    e.alu    = addr;
    e.ld     = exp_ld;
    e.isld   = mr;
    e.err    = exp_err;
    e.sticky = model_sticky;
    e.lc     = model_lc;
    e.sc     = model_sc;
    sbq.push_back(e);
    nameq.push_back(name);
  endtask

  // One idle cycle; rd/alu still register, reg_write and valid must not
  task automatic applyIdle(input logic [4:0] rd, input logic [31:0] addr);
    @(negedge clk);
    valid_in     = 1'b0;
    mem_read     = 1'b0;
    mem_write    = 1'b0;
    rd_in        = rd;
    alu_in       = addr;
    reg_write_in = 1'b1;
    @(negedge clk);
    checkOutput("idle.valid_out", 32'(valid_out), 32'd0);
    checkOutput("idle.reg_write_out", 32'(reg_write_out), 32'd0);
    checkOutput("idle.rd_out", 32'(rd_out), 32'(rd));
    checkOutput("idle.alu_out", 32'(alu_out), addr);
  endtask

  // Monitor: every valid bundle must match the oldest queued expectation
  always @(negedge clk) begin : monitor
    exp_t  e;
    string n;
    if (rst_n && valid_out) begin
      if (sbq.size() == 0) begin
        checkOutput("unexpected valid_out", 32'd1, 32'd0);
      end else begin
        e = sbq.pop_front();
        n = nameq.pop_front();
        checkOutput({n, ".rd_out"}, 32'(rd_out), 32'(e.rd));
        checkOutput({n, ".reg_write_out"}, 32'(reg_write_out), 32'(e.rw));
        checkOutput({n, ".alu_out"}, alu_out, e.alu);
        checkOutput({n, ".load_data"}, load_data, e.ld);
        checkOutput({n, ".is_load_out"}, 32'(is_load_out), 32'(e.isld));
        checkOutput({n, ".err_out"}, 32'(err_out), 32'(e.err));
        checkOutput({n, ".err_sticky"}, 32'(err_sticky), 32'(e.sticky));
        checkOutput({n, ".load_cnt"}, 32'(load_cnt), 32'(e.lc));
        checkOutput({n, ".store_cnt"}, 32'(store_cnt), 32'(e.sc));
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] timeout");
  end

  initial begin : stimulus
    int wait_cycles;
    rst_n        = 1'b0;
    valid_in     = 1'b0;
    mem_read     = 1'b0;
    mem_write    = 1'b0;
    funct3       = 3'd0;
    alu_in       = 32'd0;
    store_data   = 32'd0;
    rd_in        = 5'd0;
    reg_write_in = 1'b0;

    #1;
    checkOutput("reset.valid_out", 32'(valid_out), 32'd0);
    checkOutput("reset.load_data", load_data, 32'd0);
    checkOutput("reset.err_sticky", 32'(err_sticky), 32'd0);
    checkOutput("reset.load_cnt", 32'(load_cnt), 32'd0);
    checkOutput("reset.store_cnt", 32'(store_cnt), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] store/load basics");
    applyStimulus("sw_10",  0, 1, 3'b010, 32'h10, 32'hDEADBEEF, 5'd1, 0, 32'h0, 0);
    applyStimulus("lw_10",  1, 0, 3'b010, 32'h10, 32'h0, 5'd2, 1, 32'hDEADBEEF, 0);
    applyStimulus("sb_13",  0, 1, 3'b000, 32'h13, 32'h00000080, 5'd0, 0, 32'h0, 0);
    applyStimulus("lb_13",  1, 0, 3'b000, 32'h13, 32'h0, 5'd3, 1, 32'hFFFFFF80, 0);
    applyStimulus("lbu_13", 1, 0, 3'b100, 32'h13, 32'h0, 5'd4, 1, 32'h00000080, 0);
    applyStimulus("lw_10b", 1, 0, 3'b010, 32'h10, 32'h0, 5'd5, 1, 32'h80ADBEEF, 0);
    applyStimulus("sh_20",  0, 1, 3'b001, 32'h20, 32'h0000FFFF, 5'd0, 0, 32'h0, 0);
    applyStimulus("sh_22",  0, 1, 3'b001, 32'h22, 32'hABCD1234, 5'd0, 0, 32'h0, 0);
    applyStimulus("lhu_22", 1, 0, 3'b101, 32'h22, 32'h0, 5'd6, 1, 32'h00001234, 0);
    applyStimulus("lh_20",  1, 0, 3'b001, 32'h20, 32'h0, 5'd7, 1, 32'hFFFFFFFF, 0);
    applyStimulus("lw_20",  1, 0, 3'b010, 32'h20, 32'h0, 5'd8, 1, 32'h1234FFFF, 0);

    $display("[TB] error cases");
    applyStimulus("lw_12_mis",  1, 0, 3'b010, 32'h12, 32'h0, 5'd9, 1, 32'h0, 1);
    applyStimulus("sh_21_mis",  0, 1, 3'b001, 32'h21, 32'h0000AAAA, 5'd0, 1, 32'h0, 1);
    applyStimulus("lw_20_kept", 1, 0, 3'b010, 32'h20, 32'h0, 5'd10, 1, 32'h1234FFFF, 0);
    applyStimulus("ld_f3_011",  1, 0, 3'b011, 32'h20, 32'h0, 5'd11, 1, 32'h0, 1);
    applyStimulus("rd_and_wr",  1, 1, 3'b010, 32'h10, 32'h55555555, 5'd12, 1, 32'h0, 1);
    applyStimulus("st_f3_100",  0, 1, 3'b100, 32'h10, 32'h77777777, 5'd0, 1, 32'h0, 1);
    applyStimulus("lw_10_kept", 1, 0, 3'b010, 32'h10, 32'h0, 5'd13, 1, 32'h80ADBEEF, 0);

    $display("[TB] pass-through and aliasing");
    applyStimulus("nonmem",   0, 0, 3'b000, 32'h55, 32'h0, 5'd7, 1, 32'h0, 0);
    applyStimulus("lw_alias", 1, 0, 3'b010, 32'h1010, 32'h0, 5'd14, 1, 32'h80ADBEEF, 0);
    applyIdle(5'd9, 32'h77);

    $display("[TB] asynchronous reset during a pending store");
    @(negedge clk);
    valid_in     = 1'b1;
    mem_read     = 1'b0;
    mem_write    = 1'b1;
    funct3       = 3'b010;
    alu_in       = 32'h10;
    store_data   = 32'h11111111;
    reg_write_in = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async_rst.valid_out", 32'(valid_out), 32'd0);
    checkOutput("async_rst.alu_out", alu_out, 32'd0);
    checkOutput("async_rst.err_sticky", 32'(err_sticky), 32'd0);
    checkOutput("async_rst.load_cnt", 32'(load_cnt), 32'd0);
    checkOutput("async_rst.store_cnt", 32'(store_cnt), 32'd0);
    @(negedge clk);
    valid_in  = 1'b0;
    mem_write = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_lc     = '0;
    model_sc     = '0;
    model_sticky = 1'b0;

    applyStimulus("lw_after_rst", 1, 0, 3'b010, 32'h10, 32'h0, 5'd15, 1, 32'h80ADBEEF, 0);

    $display("[TB] load counter saturation");
    for (int i = 0; i < 17; i++) begin
      applyStimulus("lw_sat", 1, 0, 3'b010, 32'h10, 32'h0, 5'd16, 1, 32'h80ADBEEF, 0);
    end

    @(negedge clk);
    valid_in  = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    wait_cycles = 0;
    while (sbq.size() != 0 && wait_cycles < 10) begin
      @(negedge clk);
      wait_cycles++;
    end
    checkOutput("drain.pending_bundles", 32'(sbq.size()), 32'd0);
    checkOutput("final.load_cnt_saturated", 32'(load_cnt), 32'hF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
